// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide unit holding the HI/LO registers.
// A MULT/MULTU/DIV/DIVU result is computed on the start edge and parked in
// pending registers. The FSM then stays busy for a fixed number of cycles
// and commits the pending value to HI/LO on the final edge.
module md_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        D_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic               pend_vld_q, pend_vld_d;

  logic               is_signed_s;
  logic [63:0]        a_ext_s, b_ext_s, prod_s;
  logic [31:0]        a_mag_s, b_mag_s, uq_s, ur_s, quot_s, rem_s;
  logic               neg_q_s, neg_r_s;

  // Datapath: 64-bit product and sign-magnitude division (avoids the
  // 0x80000000 / -1 overflow corner of native signed division).
  always_comb begin
    is_signed_s = ~md_op[0];
    a_ext_s     = {{32{is_signed_s & rs_val[31]}}, rs_val};
    b_ext_s     = {{32{is_signed_s & rt_val[31]}}, rt_val};
    prod_s      = a_ext_s * b_ext_s;
    neg_q_s     = is_signed_s & (rs_val[31] ^ rt_val[31]);
    neg_r_s     = is_signed_s & rs_val[31];
    a_mag_s     = (is_signed_s & rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    b_mag_s     = (is_signed_s & rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    if (rt_val != 32'd0) begin
      uq_s = a_mag_s / b_mag_s;
      ur_s = a_mag_s % b_mag_s;
    end else begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end
    quot_s = neg_q_s ? (32'd0 - uq_s) : uq_s;
    rem_s  = neg_r_s ? (32'd0 - ur_s) : ur_s;
  end

  // Next-state logic: operation launch in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_vld_d = pend_vld_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1: begin
              pend_hi_d  = prod_s[63:32];
              pend_lo_d  = prod_s[31:0];
              pend_vld_d = 1'b1;
              cnt_d      = CNT_W'(MUL_CYCLES);
              state_d    = RUN;
            end
            3'd2, 3'd3: begin
              // A zero divisor still occupies the unit but commits nothing.
              pend_hi_d  = rem_s;
              pend_lo_d  = quot_s;
              pend_vld_d = (rt_val != 32'd0);
              cnt_d      = CNT_W'(DIV_CYCLES);
              state_d    = RUN;
            end
            3'd4: begin
              hi_d = rs_val;
            end
            3'd5: begin
              lo_d = rs_val;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q <= CNT_W'(1)) begin
          if (pend_vld_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Stall while busy, and on the launch cycle of a multi-cycle op.
  assign md_stall = D_is_md & (busy | (start & (md_op <= 3'd3)));

endmodule
